// File: rtl/tile_wb_arbiter.sv
// Two-master Wishbone arbiter for the 128-bit tile bus.
// Master 0 is the CPU core, master 1 the DMA engine. The grant is held for the
// owner's whole cycle, the request side is muxed onto the shared bus, and
// responses go only to the owner. A watchdog ends hung strobes with an error.
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | no owner, shared bus driven to zero
// GNT0  | CPU owns the shared bus until it drops cyc
// GNT1  | DMA owns the shared bus until it drops cyc
module tile_wb_arbiter #(
  parameter int CPU_PRIORITY = 1,
  parameter int TIMEOUT      = 1024
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_m0_cyc,
  input  logic         i_m0_stb,
  input  logic         i_m0_we,
  input  logic [31:0]  i_m0_adr,
  input  logic [15:0]  i_m0_sel,
  input  logic [127:0] i_m0_dat,
  output logic [127:0] o_m0_dat,
  output logic         o_m0_ack,
  output logic         o_m0_err,
  input  logic         i_m1_cyc,
  input  logic         i_m1_stb,
  input  logic         i_m1_we,
  input  logic [31:0]  i_m1_adr,
  input  logic [15:0]  i_m1_sel,
  input  logic [127:0] i_m1_dat,
  output logic [127:0] o_m1_dat,
  output logic         o_m1_ack,
  output logic         o_m1_err,
  output logic         o_wb_cyc,
  output logic         o_wb_stb,
  output logic         o_wb_we,
  output logic [31:0]  o_wb_adr,
  output logic [15:0]  o_wb_sel,
  output logic [127:0] o_wb_dat,
  input  logic [127:0] i_wb_dat,
  input  logic         i_wb_ack,
  input  logic         i_wb_err,
  output logic [1:0]   o_gnt,
  output logic         o_timeout
);

  // State codes double as the one-hot grant vector.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] GNT0 = 2'b01;
  localparam logic [1:0] GNT1 = 2'b10;

  // TIMEOUT of 0 turns the watchdog off entirely.
  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        last;
  logic        last_nxt;
  logic [15:0] wait_cnt;
  logic        to_flag;
  logic        own0;
  logic        own1;
  logic        stb_raw;
  logic        unanswered;
  logic        fire;

  assign own0 = (state == GNT0);
  assign own1 = (state == GNT1);

  // Next grant: no preemption; release hands over directly when the other master waits.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc) begin
          if (CPU_PRIORITY != 0) state_nxt = GNT0;
          else                   state_nxt = last ? GNT0 : GNT1;
        end else if (i_m0_cyc) begin
          state_nxt = GNT0;
        end else if (i_m1_cyc) begin
          state_nxt = GNT1;
        end
      end
      GNT0: begin
        if (!i_m0_cyc) begin
          last_nxt  = 1'b0;
          state_nxt = i_m1_cyc ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!i_m1_cyc) begin
          last_nxt  = 1'b1;
          state_nxt = i_m0_cyc ? GNT0 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant state and round-robin history; last resets to 1 so the CPU wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Request mux from the registered grant; everything zero while idle.
  always_comb begin
    o_wb_cyc = 1'b0;
    stb_raw  = 1'b0;
    o_wb_we  = 1'b0;
    o_wb_adr = '0;
    o_wb_sel = '0;
    o_wb_dat = '0;
    if (own0) begin
      o_wb_cyc = i_m0_cyc;
      stb_raw  = i_m0_cyc & i_m0_stb;
      o_wb_we  = i_m0_we;
      o_wb_adr = i_m0_adr;
      o_wb_sel = i_m0_sel;
      o_wb_dat = i_m0_dat;
    end else if (own1) begin
      o_wb_cyc = i_m1_cyc;
      stb_raw  = i_m1_cyc & i_m1_stb;
      o_wb_we  = i_m1_we;
      o_wb_adr = i_m1_adr;
      o_wb_sel = i_m1_sel;
      o_wb_dat = i_m1_dat;
    end
  end

  // The timeout cycle withdraws the strobe and swallows any late ack.
  assign o_wb_stb  = stb_raw & ~to_flag;
  assign o_m0_dat  = i_wb_dat;
  assign o_m1_dat  = i_wb_dat;
  assign o_m0_ack  = i_wb_ack & own0 & i_m0_cyc & ~to_flag;
  assign o_m1_ack  = i_wb_ack & own1 & i_m1_cyc & ~to_flag;
  assign o_m0_err  = own0 & i_m0_cyc & (i_wb_err | to_flag);
  assign o_m1_err  = own1 & i_m1_cyc & (i_wb_err | to_flag);
  assign o_gnt     = state;
  assign o_timeout = to_flag;

  assign unanswered = o_wb_stb & ~i_wb_ack & ~i_wb_err & (state_nxt == state);
  assign fire       = WD_EN & unanswered & (wait_cnt == TO_LAST);

  // Watchdog: count unanswered strobe cycles, flag the cycle after the last allowed one.
  always_ff @(posedge i_clk) begin
    if (i_rst || !WD_EN) begin
      wait_cnt <= '0;
      to_flag  <= 1'b0;
    end else begin
      to_flag  <= fire;
      if (unanswered && !fire) wait_cnt <= wait_cnt + 16'd1;
      else                     wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_tile_wb_arbiter.sv
// Directed bench for tile_wb_arbiter: dut_a uses CPU priority with an 8-cycle
// watchdog, dut_b uses round-robin with the watchdog disabled. Both share inputs.
module tb_tile_wb_arbiter;

  localparam logic [31:0]  A0    = 32'h0000_0100;
  localparam logic [31:0]  A1    = 32'h8000_1000;
  localparam logic [15:0]  SEL0  = 16'h000F;
  localparam logic [15:0]  SEL1  = 16'hF000;
  localparam logic [127:0] DAT0  = 128'h11;
  localparam logic [127:0] DAT1  = 128'h22;
  localparam logic [127:0] WBDAT = 128'hA5;

  logic         clk;
  logic         rst;
  logic         m0_cyc, m0_stb, m0_we;
  logic [31:0]  m0_adr;
  logic [15:0]  m0_sel;
  logic [127:0] m0_dat;
  logic         m1_cyc, m1_stb, m1_we;
  logic [31:0]  m1_adr;
  logic [15:0]  m1_sel;
  logic [127:0] m1_dat;
  logic [127:0] wb_dat_in;
  logic         wb_ack, wb_err;

  logic [127:0] a_m0_dat, a_m1_dat, a_wb_dat, b_m0_dat, b_m1_dat, b_wb_dat;
  logic         a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_wb_cyc, a_wb_stb, a_wb_we, a_to;
  logic         b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_wb_cyc, b_wb_stb, b_wb_we, b_to;
  logic [31:0]  a_wb_adr, b_wb_adr;
  logic [15:0]  a_wb_sel, b_wb_sel;
  logic [1:0]   a_gnt, b_gnt;

  int checks   = 0;
  int failures = 0;

  tile_wb_arbiter #(.CPU_PRIORITY(1), .TIMEOUT(8)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_adr(m0_adr),
    .i_m0_sel(m0_sel), .i_m0_dat(m0_dat),
    .o_m0_dat(a_m0_dat), .o_m0_ack(a_m0_ack), .o_m0_err(a_m0_err),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_adr(m1_adr),
    .i_m1_sel(m1_sel), .i_m1_dat(m1_dat),
    .o_m1_dat(a_m1_dat), .o_m1_ack(a_m1_ack), .o_m1_err(a_m1_err),
    .o_wb_cyc(a_wb_cyc), .o_wb_stb(a_wb_stb), .o_wb_we(a_wb_we), .o_wb_adr(a_wb_adr),
    .o_wb_sel(a_wb_sel), .o_wb_dat(a_wb_dat),
    .i_wb_dat(wb_dat_in), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
    .o_gnt(a_gnt), .o_timeout(a_to)
  );

  tile_wb_arbiter #(.CPU_PRIORITY(0), .TIMEOUT(0)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_adr(m0_adr),
    .i_m0_sel(m0_sel), .i_m0_dat(m0_dat),
    .o_m0_dat(b_m0_dat), .o_m0_ack(b_m0_ack), .o_m0_err(b_m0_err),
    .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_adr(m1_adr),
    .i_m1_sel(m1_sel), .i_m1_dat(m1_dat),
    .o_m1_dat(b_m1_dat), .o_m1_ack(b_m1_ack), .o_m1_err(b_m1_err),
    .o_wb_cyc(b_wb_cyc), .o_wb_stb(b_wb_stb), .o_wb_we(b_wb_we), .o_wb_adr(b_wb_adr),
    .o_wb_sel(b_wb_sel), .o_wb_dat(b_wb_dat),
    .i_wb_dat(wb_dat_in), .i_wb_ack(wb_ack), .i_wb_err(wb_err),
    .o_gnt(b_gnt), .o_timeout(b_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        c0, s0, c1, s1, ack, err;
    logic [1:0]  gnt;
    logic        wcyc, wstb, a0, e0, a1, e1, to;
    logic [31:0] adr;
  } vec_t;

  vec_t tbl [0:26];

  function automatic vec_t mk(input logic c0, s0, c1, s1, ack, err,
                              input logic [1:0] gnt,
                              input logic wcyc, wstb, a0, e0, a1, e1, to,
                              input logic [31:0] adr);
    vec_t v;
    v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack; v.err = err;
    v.gnt = gnt; v.wcyc = wcyc; v.wstb = wstb;
    v.a0 = a0; v.e0 = e0; v.a1 = a1; v.e1 = e1; v.to = to; v.adr = adr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // One bus cycle: drive just after the rising edge, return at the falling edge.
  task automatic step(input logic r, c0, s0, c1, s1, ack, err);
    @(posedge clk);
    #1;
    rst = r; m0_cyc = c0; m0_stb = s0; m1_cyc = c1; m1_stb = s1;
    wb_ack = ack; wb_err = err;
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic         sticky;
  logic [15:0]  esel;
  logic         ewe;
  logic [127:0] edat;

  initial begin
    rst = 1'b1;
    m0_cyc = 0; m0_stb = 0; m0_we = 1'b0; m0_adr = A0; m0_sel = SEL0; m0_dat = DAT0;
    m1_cyc = 0; m1_stb = 0; m1_we = 1'b1; m1_adr = A1; m1_sel = SEL1; m1_dat = DAT1;
    wb_dat_in = WBDAT; wb_ack = 0; wb_err = 0;

    //            c0 s0 c1 s1 ak er  gnt   cyc stb a0 e0 a1 e1 to adr
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    tbl[1]  = mk(1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    tbl[2]  = mk(1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0, A0);
    tbl[3]  = mk(1, 1, 0, 0, 1, 0, 2'b01, 1, 1, 1, 0, 0, 0, 0, A0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, A0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    tbl[6]  = mk(1, 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    tbl[7]  = mk(1, 1, 1, 1, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0, A0);
    tbl[8]  = mk(1, 1, 1, 1, 1, 0, 2'b01, 1, 1, 1, 0, 0, 0, 0, A0);
    tbl[9]  = mk(1, 0, 1, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0, A0);
    tbl[10] = mk(0, 0, 1, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, A0);
    tbl[11] = mk(0, 0, 1, 1, 0, 0, 2'b10, 1, 1, 0, 0, 0, 0, 0, A1);
    tbl[12] = mk(0, 0, 1, 1, 0, 1, 2'b10, 1, 1, 0, 0, 0, 1, 0, A1);
    tbl[13] = mk(0, 0, 0, 0, 1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, A1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    tbl[15] = mk(0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 16; i < 24; i++)
      tbl[i] = mk(0, 0, 1, 1, 0, 0, 2'b10, 1, 1, 0, 0, 0, 0, 0, A1);
    tbl[24] = mk(0, 0, 1, 1, 1, 0, 2'b10, 1, 0, 0, 0, 0, 1, 1, A1);
    tbl[25] = mk(0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, A1);
    tbl[26] = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Table: single read, priority tie, handover, error, masked ack, watchdog on dut_a.
    for (int i = 0; i < 27; i++) begin
      step(1'b0, tbl[i].c0, tbl[i].s0, tbl[i].c1, tbl[i].s1, tbl[i].ack, tbl[i].err);
      case (tbl[i].gnt)
        2'b01:   begin esel = SEL0; ewe = 1'b0; edat = DAT0; end
        2'b10:   begin esel = SEL1; ewe = 1'b1; edat = DAT1; end
        default: begin esel = '0;   ewe = 1'b0; edat = '0;   end
      endcase
      chk($sformatf("row%0d gnt", i),     a_gnt,    tbl[i].gnt);
      chk($sformatf("row%0d wb_cyc", i),  a_wb_cyc, tbl[i].wcyc);
      chk($sformatf("row%0d wb_stb", i),  a_wb_stb, tbl[i].wstb);
      chk($sformatf("row%0d m0_ack", i),  a_m0_ack, tbl[i].a0);
      chk($sformatf("row%0d m0_err", i),  a_m0_err, tbl[i].e0);
      chk($sformatf("row%0d m1_ack", i),  a_m1_ack, tbl[i].a1);
      chk($sformatf("row%0d m1_err", i),  a_m1_err, tbl[i].e1);
      chk($sformatf("row%0d timeout", i), a_to,     tbl[i].to);
      chk($sformatf("row%0d wb_adr", i),  a_wb_adr, tbl[i].adr);
      chk($sformatf("row%0d wb_sel", i),  a_wb_sel, esel);
      chk($sformatf("row%0d wb_we", i),   a_wb_we,  ewe);
      chk($sformatf("row%0d wb_dat", i),  a_wb_dat, edat);
      if (tbl[i].a0) chk($sformatf("row%0d m0_dat", i), a_m0_dat, WBDAT);
    end

    // Reset while the DMA owns the bus, after the CPU left last at 0.
    do_reset();
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    chk("rstmid pre b_gnt", b_gnt, 2'b10);
    step(1, 0, 0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 1, 1, 1);
    chk("rstmid a_gnt",    a_gnt,    2'b00);
    chk("rstmid b_gnt",    b_gnt,    2'b00);
    chk("rstmid a_wb_cyc", a_wb_cyc, 1'b0);
    chk("rstmid b_wb_cyc", b_wb_cyc, 1'b0);
    chk("rstmid b_wb_stb", b_wb_stb, 1'b0);
    chk("rstmid a_m1_ack", a_m1_ack, 1'b0);
    chk("rstmid a_m1_err", a_m1_err, 1'b0);
    chk("rstmid b_m1_ack", b_m1_ack, 1'b0);
    chk("rstmid b_m1_err", b_m1_err, 1'b0);
    chk("rstmid b_m0_ack", b_m0_ack, 1'b0);
    chk("rstmid b_m0_err", b_m0_err, 1'b0);
    step(0, 1, 1, 1, 1, 0, 0);
    chk("postrst b_gnt",    b_gnt,    2'b01);
    chk("postrst a_gnt",    a_gnt,    2'b01);
    chk("postrst b_wb_adr", b_wb_adr, A0);
    chk("postrst b_wb_sel", b_wb_sel, SEL0);
    chk("postrst b_wb_we",  b_wb_we,  1'b0);
    chk("postrst b_wb_dat", b_wb_dat, DAT0);
    chk("postrst b_m0_dat", b_m0_dat, WBDAT);
    chk("postrst b_m1_dat", b_m1_dat, WBDAT);
    chk("postrst a_m1_dat", a_m1_dat, WBDAT);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Round-robin on dut_b: both masters keep requesting with 2-cycle transfers.
    do_reset();
    step(0, 1, 1, 1, 1, 0, 0);
    chk("rr req b_gnt", b_gnt, 2'b00);
    for (int g = 0; g < 4; g++) begin
      logic [1:0] eg;
      eg = (g % 2 == 0) ? 2'b01 : 2'b10;
      step(0, 1, 1, 1, 1, 1, 0);
      chk($sformatf("rr%0d gnt", g),    b_gnt,    eg);
      chk($sformatf("rr%0d wb_cyc", g), b_wb_cyc, 1'b1);
      chk($sformatf("rr%0d m0_ack", g), b_m0_ack, (g % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("rr%0d m1_ack", g), b_m1_ack, (g % 2 == 0) ? 1'b0 : 1'b1);
      step(0, 1, 1, 1, 1, 0, 0);
      chk($sformatf("rr%0d gnt2", g),   b_gnt,    eg);
      if (g % 2 == 0) step(0, 0, 0, 1, 1, 0, 0);
      else            step(0, 1, 1, 0, 0, 0, 0);
      chk($sformatf("rr%0d rel gnt", g), b_gnt,    eg);
      chk($sformatf("rr%0d rel cyc", g), b_wb_cyc, 1'b0);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rr cpu release gnt", b_gnt, 2'b01);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rr idle gnt", b_gnt, 2'b00);
    step(0, 1, 1, 1, 1, 0, 0);
    step(0, 1, 1, 1, 1, 0, 0);
    chk("rr tie last0 b_gnt", b_gnt, 2'b10);
    chk("prio tie a_gnt",     a_gnt, 2'b01);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Watchdog disabled on dut_b: an unanswered strobe runs past 16-bit wrap.
    do_reset();
    step(0, 0, 0, 1, 1, 0, 0);
    sticky = 1'b0;
    for (int n = 0; n < 70000; n++) begin
      @(posedge clk);
      @(negedge clk);
      sticky = sticky | b_to | b_m1_err;
    end
    chk("to0 no timeout/err", sticky,   1'b0);
    chk("to0 gnt held",       b_gnt,    2'b10);
    chk("to0 stb held",       b_wb_stb, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
